// File: rtl/util_trafic_checker_pkg.sv
// Shared constants for the traffic checker: FSM state codes, error-flag bit
// indices (also used by the test-status register wrappers) and counter helpers.
package util_trafic_checker_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_SEED  = 2'd1;
   localparam state_t ST_CHECK = 2'd2;

   localparam int ERR_DATA = 0;
   localparam int ERR_KEEP = 1;
   localparam int ERR_SB   = 2;
   localparam int NUM_ERR  = 3;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == '1) ? v : v + 32'd1;
   endfunction

   function automatic logic [63:0] sat_inc64(input logic [63:0] v);
      return (v == '1) ? v : v + 64'd1;
   endfunction

endpackage

// File: rtl/util_trafic_checker_rate_meter.sv
// Beat-rate meter: counts beats over a fixed window of clock cycles and
// publishes the total with a one-cycle valid pulse at each window end.
module util_rate_meter
   import util_trafic_checker_pkg::*;
#(
   parameter longint unsigned WIN_CYCLES = 64'd150_000_000
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic        en_i,
   input  logic        clr_i,
   input  logic        beat_i,
   output logic [31:0] rate_o,
   output logic        rate_vld_o
);

   logic [63:0] win_q, win_d;
   logic [31:0] acc_q, acc_d, acc_inc;
   logic [31:0] rate_q, rate_d;
   logic        vld_q, vld_d;
   logic        term;

   assign acc_inc = beat_i ? sat_inc32(acc_q) : acc_q;
   assign term    = (win_q == WIN_CYCLES - 64'd1);

   always_comb begin
      win_d  = win_q;
      acc_d  = acc_q;
      rate_d = rate_q;
      vld_d  = 1'b0;
      if (!en_i) begin
         win_d = '0;
      end else begin
         win_d = term ? '0 : win_q + 64'd1;
         acc_d = acc_inc;
         // the terminal-cycle beat lands in the published rate, not the next window
         if (term) begin
            rate_d = acc_inc;
            acc_d  = '0;
            vld_d  = 1'b1;
         end
         if (clr_i) acc_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         win_q  <= '0;
         acc_q  <= '0;
         rate_q <= '0;
         vld_q  <= 1'b0;
      end else begin
         win_q  <= win_d;
         acc_q  <= acc_d;
         rate_q <= rate_d;
         vld_q  <= vld_d;
      end
   end

   assign rate_o     = rate_q;
   assign rate_vld_o = vld_q;

endmodule

// File: rtl/util_trafic_checker.sv
// AXI4-Stream sink checking an incrementing-counter pattern with zero sideband;
// reports error statistics, pattern lock and accepted-beat rate.
module util_trafic_checker
   import util_trafic_checker_pkg::*;
#(
   parameter longint unsigned CLK_FREQ   = 64'd150_000_000,
   parameter longint unsigned WIN_CYCLES = CLK_FREQ,
   parameter int unsigned     READY_DIV  = 0,
   parameter int unsigned     LOCK_BEATS = 16,
   parameter longint unsigned TBYTE_NUM  = 64'd16,
   parameter int unsigned     ID_WIDTH   = 5,
   parameter int unsigned     DEST_WIDTH = 5
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          en,
   input  logic                          clr,
   input  logic                          s_axis_tvalid,
   output logic                          s_axis_tready,
   input  logic [int'(TBYTE_NUM)*8-1:0]  s_axis_tdata,
   input  logic [int'(TBYTE_NUM)-1:0]    s_axis_tkeep,
   input  logic                          s_axis_tlast,
   input  logic [ID_WIDTH-1:0]           s_axis_tid,
   input  logic [DEST_WIDTH-1:0]         s_axis_tdest,
   output logic                          locked,
   output logic                          err_pulse,
   output logic [2:0]                    err_flags,
   output logic [31:0]                   err_cnt,
   output logic [63:0]                   beat_cnt,
   output logic [31:0]                   rate,
   output logic                          rate_vld
);

   localparam int DW = int'(TBYTE_NUM) * 8;

   state_t               state_q, state_d;
   logic [DW-1:0]        exp_q, exp_d;
   logic [31:0]          good_q, good_d;
   logic [31:0]          div_q, div_d;
   logic [31:0]          ecnt_q, ecnt_d;
   logic [63:0]          bcnt_q, bcnt_d;
   logic [NUM_ERR-1:0]   flags_q, flags_d, err_vec;
   logic                 locked_q, locked_d;
   logic                 pulse_q, pulse_d;
   logic                 tready_q, tready_d;
   logic                 accept;

   assign accept = s_axis_tvalid & tready_q;

   always_ff @(posedge clk) begin
      if (!rstn) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (!en) begin
         state_d = ST_IDLE;
      end else if (clr) begin
         state_d = ST_SEED;
      end else begin
         case (state_q)
            ST_IDLE:  state_d = ST_SEED;
            ST_SEED:  if (accept) state_d = ST_CHECK;
            ST_CHECK: state_d = ST_CHECK;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      err_vec           = '0;
      err_vec[ERR_DATA] = (s_axis_tdata != exp_q);
      err_vec[ERR_KEEP] = (s_axis_tkeep != '1);
      err_vec[ERR_SB]   = (|s_axis_tid) | (|s_axis_tdest) | s_axis_tlast;
   end

   always_comb begin
      exp_d    = exp_q;
      good_d   = good_q;
      ecnt_d   = ecnt_q;
      bcnt_d   = bcnt_q;
      flags_d  = flags_q;
      locked_d = locked_q;
      pulse_d  = 1'b0;
      if (!en) begin
         locked_d = 1'b0;
         good_d   = '0;
      end else if (clr) begin
         // a beat accepted alongside clr is consumed but ignored
         ecnt_d   = '0;
         bcnt_d   = '0;
         flags_d  = '0;
         locked_d = 1'b0;
         good_d   = '0;
      end else if (accept && state_q != ST_IDLE) begin
         bcnt_d = sat_inc64(bcnt_q);
         exp_d  = s_axis_tdata + DW'(1);
         if (state_q == ST_CHECK) begin
            if (|err_vec) begin
               pulse_d  = 1'b1;
               ecnt_d   = sat_inc32(ecnt_q);
               flags_d  = flags_q | err_vec;
               good_d   = '0;
               locked_d = 1'b0;
            end else begin
               if (good_q < LOCK_BEATS) good_d = good_q + 32'd1;
               locked_d = (good_d >= LOCK_BEATS);
            end
         end
      end

      // ready divider restarts on every return to an active state
      if (state_d == ST_IDLE)              div_d = '0;
      else if (div_q == 32'(READY_DIV))    div_d = '0;
      else                                 div_d = div_q + 32'd1;
      tready_d = (state_d != ST_IDLE) && (div_q == '0);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         exp_q    <= '0;
         good_q   <= '0;
         div_q    <= '0;
         ecnt_q   <= '0;
         bcnt_q   <= '0;
         flags_q  <= '0;
         locked_q <= 1'b0;
         pulse_q  <= 1'b0;
         tready_q <= 1'b0;
      end else begin
         exp_q    <= exp_d;
         good_q   <= good_d;
         div_q    <= div_d;
         ecnt_q   <= ecnt_d;
         bcnt_q   <= bcnt_d;
         flags_q  <= flags_d;
         locked_q <= locked_d;
         pulse_q  <= pulse_d;
         tready_q <= tready_d;
      end
   end

   util_rate_meter #(
      .WIN_CYCLES (WIN_CYCLES)
   ) u_rate (
      .clk_i      (clk),
      .rstn_i     (rstn),
      .en_i       (en),
      .clr_i      (clr),
      .beat_i     (accept & ~clr),
      .rate_o     (rate),
      .rate_vld_o (rate_vld)
   );

   assign s_axis_tready = tready_q;
   assign locked        = locked_q;
   assign err_pulse     = pulse_q;
   assign err_flags     = flags_q;
   assign err_cnt       = ecnt_q;
   assign beat_cnt      = bcnt_q;

endmodule

// File: tb/tb_util_trafic_checker.sv
// Scoreboard bench: a wide-beat instance fed by directed and random streams
// checked against a rule-level model, plus a narrow back-pressured instance.
module tb_util_trafic_checker;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // wide instance, always ready
   logic         en = 1'b0, clr = 1'b0, tvalid = 1'b0, tready, tlast = 1'b0;
   logic [127:0] tdata = '0;
   logic [15:0]  tkeep = '1;
   logic [4:0]   tid = '0, tdest = '0;
   logic         locked, err_pulse, rate_vld;
   logic [2:0]   err_flags;
   logic [31:0]  err_cnt, rate;
   logic [63:0]  beat_cnt;

   // narrow instance, ready 1 of 4
   logic         en_b = 1'b0, clr_b = 1'b0, tvalid_b = 1'b0, tready_b, tlast_b = 1'b0;
   logic [7:0]   tdata_b = '0;
   logic [0:0]   tkeep_b = 1'b1;
   logic [4:0]   tid_b = '0, tdest_b = '0;
   logic         locked_b, err_pulse_b, rate_vld_b;
   logic [2:0]   err_flags_b;
   logic [31:0]  err_cnt_b, rate_b;
   logic [63:0]  beat_cnt_b;

   util_trafic_checker #(
      .WIN_CYCLES(64'd100), .READY_DIV(0), .LOCK_BEATS(16), .TBYTE_NUM(64'd16)
   ) dut (
      .clk(clk), .rstn(rstn), .en(en), .clr(clr),
      .s_axis_tvalid(tvalid), .s_axis_tready(tready), .s_axis_tdata(tdata),
      .s_axis_tkeep(tkeep), .s_axis_tlast(tlast), .s_axis_tid(tid), .s_axis_tdest(tdest),
      .locked(locked), .err_pulse(err_pulse), .err_flags(err_flags), .err_cnt(err_cnt),
      .beat_cnt(beat_cnt), .rate(rate), .rate_vld(rate_vld)
   );

   util_trafic_checker #(
      .WIN_CYCLES(64'd100), .READY_DIV(3), .LOCK_BEATS(16), .TBYTE_NUM(64'd1)
   ) dut_b (
      .clk(clk), .rstn(rstn), .en(en_b), .clr(clr_b),
      .s_axis_tvalid(tvalid_b), .s_axis_tready(tready_b), .s_axis_tdata(tdata_b),
      .s_axis_tkeep(tkeep_b), .s_axis_tlast(tlast_b), .s_axis_tid(tid_b), .s_axis_tdest(tdest_b),
      .locked(locked_b), .err_pulse(err_pulse_b), .err_flags(err_flags_b), .err_cnt(err_cnt_b),
      .beat_cnt(beat_cnt_b), .rate(rate_b), .rate_vld(rate_vld_b)
   );

   typedef struct {
      logic        pulse;
      logic [2:0]  flags;
      logic [31:0] ecnt;
      logic [63:0] bcnt;
      logic        locked;
   } exp_t;

   exp_t sb[$];

   // reference model state
   bit           m_seeded;
   logic [127:0] m_exp;
   int           m_good;
   logic [31:0]  m_ecnt;
   logic [63:0]  m_bcnt;
   logic [2:0]   m_flags;
   bit           m_locked;

   task automatic chk(input bit ok, input string nm, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic model_clear();
      m_seeded = 0; m_good = 0; m_ecnt = '0; m_bcnt = '0; m_flags = '0; m_locked = 0;
   endtask

   task automatic model_beat(input logic [127:0] d, input logic [15:0] k, input logic l,
                             input logic [4:0] id, input logic [4:0] de, input logic c);
      exp_t e;
      bit   bad;
      e.pulse = 1'b0;
      if (c) begin
         model_clear();
      end else if (!m_seeded) begin
         m_seeded = 1;
         m_exp    = d + 128'd1;
         m_bcnt   = m_bcnt + 64'd1;
      end else begin
         m_bcnt = m_bcnt + 64'd1;
         bad = 0;
         if (d != m_exp)                         begin m_flags[0] = 1'b1; bad = 1; end
         if (k != 16'hFFFF)                      begin m_flags[1] = 1'b1; bad = 1; end
         if (id != 0 || de != 0 || l)            begin m_flags[2] = 1'b1; bad = 1; end
         if (bad) begin
            m_ecnt = m_ecnt + 32'd1; m_good = 0; m_locked = 0; e.pulse = 1'b1;
         end else begin
            if (m_good < 16) m_good++;
            m_locked = (m_good == 16);
         end
         m_exp = d + 128'd1;
      end
      e.flags = m_flags; e.ecnt = m_ecnt; e.bcnt = m_bcnt; e.locked = m_locked;
      sb.push_back(e);
   endtask

   task automatic send(input logic [127:0] d, input logic [15:0] k, input logic l,
                       input logic [4:0] id, input logic [4:0] de, input logic c);
      bit ok = 0;
      tvalid = 1'b1; tdata = d; tkeep = k; tlast = l; tid = id; tdest = de; clr = c;
      for (int n = 0; n < 20; n++) begin
         @(posedge clk);
         if (tready) begin ok = 1; break; end
      end
      if (ok) model_beat(d, k, l, id, de, c);
      else    chk(1'b0, "tready_timeout", 128'(tready), 128'd1);
      #1;
      tvalid = 1'b0; clr = 1'b0; tkeep = '1; tlast = 1'b0; tid = '0; tdest = '0;
   endtask

   task automatic send_ok(input logic [127:0] d);
      send(d, 16'hFFFF, 1'b0, 5'd0, 5'd0, 1'b0);
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic do_clr();
      clr = 1'b1;
      @(posedge clk);
      model_clear();
      #1;
      clr = 1'b0;
   endtask

   // monitor: pops one expectation per accepted beat, otherwise err_pulse must be low
   initial begin
      bit   acc;
      exp_t e;
      forever begin
         @(posedge clk);
         acc = rstn && tvalid && tready;
         #1;
         if (acc) begin
            if (sb.size() == 0) begin
               chk(1'b0, "sb_empty", 128'd0, 128'd1);
            end else begin
               e = sb.pop_front();
               chk({err_pulse, err_flags, err_cnt, beat_cnt, locked} ==
                   {e.pulse, e.flags, e.ecnt, e.bcnt, e.locked}, "sb_beat",
                   128'({err_pulse, err_flags, err_cnt, beat_cnt, locked}),
                   128'({e.pulse, e.flags, e.ecnt, e.bcnt, e.locked}));
            end
         end else begin
            chk(err_pulse == 1'b0, "pulse_idle", 128'(err_pulse), 128'd0);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] d, nd;
      logic [15:0]  k;
      logic         l;
      logic [4:0]   id, de;
      int           r, nacc, last_rdy, last_vld, nvld;
      bit           accb;

      model_clear();
      m_exp = '0;
      repeat (3) @(posedge clk);
      #1;
      chk({tready, locked, err_pulse, err_flags, err_cnt, beat_cnt, rate, rate_vld} == '0,
          "reset_outputs", 128'({err_flags, err_cnt, beat_cnt}), 128'd0);
      chk({tready_b, locked_b, err_pulse_b, err_cnt_b, beat_cnt_b, rate_b} == '0,
          "reset_outputs_b", 128'({err_cnt_b, beat_cnt_b}), 128'd0);
      rstn = 1'b1;

      // narrow instance: back-pressure pattern, rate windows, wrap through 8'hFF
      en_b = 1'b1; tvalid_b = 1'b1; tdata_b = 8'hFD;
      nacc = 0; last_rdy = -1; last_vld = -1; nvld = 0;
      for (int cyc = 0; cyc < 420; cyc++) begin
         @(posedge clk);
         accb = tready_b;
         if (accb) nacc++;
         #1;
         if (cyc == 0) chk(tready_b == 1'b1, "tready_rise", 128'(tready_b), 128'd1);
         if (tready_b) begin
            if (last_rdy >= 0) chk(cyc - last_rdy == 4, "tready_period", 128'(cyc - last_rdy), 128'd4);
            last_rdy = cyc;
         end
         if (rate_vld_b) begin
            chk(rate_b == 32'd25, "rate_value", 128'(rate_b), 128'd25);
            if (last_vld >= 0) chk(cyc - last_vld == 100, "rate_period", 128'(cyc - last_vld), 128'd100);
            last_vld = cyc;
            nvld++;
         end
         if (accb) tdata_b = tdata_b + 8'd1;
      end
      chk(nvld == 4, "rate_vld_count", 128'(nvld), 128'd4);
      chk(err_cnt_b == 32'd0, "wrap_err_cnt", 128'(err_cnt_b), 128'd0);
      chk(beat_cnt_b == 64'(nacc), "wrap_beat_cnt", 128'(beat_cnt_b), 128'(nacc));
      chk(locked_b == 1'b1, "wrap_locked", 128'(locked_b), 128'd1);
      tvalid_b = 1'b0; en_b = 1'b0;

      // clean counting stream
      en = 1'b1;
      for (int i = 0; i < 100; i++) send_ok(128'(i));
      chk(beat_cnt == 64'd100, "clean_beat_cnt", 128'(beat_cnt), 128'd100);
      chk(err_cnt == 32'd0, "clean_err_cnt", 128'(err_cnt), 128'd0);
      chk(locked == 1'b1, "clean_locked", 128'(locked), 128'd1);

      // one dropped beat
      do_clr();
      for (int i = 0; i < 100; i++) if (i != 50) send_ok(128'(i));
      chk(err_cnt == 32'd1, "gap_err_cnt", 128'(err_cnt), 128'd1);
      chk(err_flags == 3'b001, "gap_flags", 128'(err_flags), 128'd1);
      chk(locked == 1'b1, "gap_relock", 128'(locked), 128'd1);

      // keep and tlast errors on otherwise correct data
      do_clr();
      for (int i = 0; i < 40; i++) begin
         if (i == 10)      send(128'(i), 16'h7FFF, 1'b0, 5'd0, 5'd0, 1'b0);
         else if (i == 20) send(128'(i), 16'hFFFF, 1'b1, 5'd0, 5'd0, 1'b0);
         else              send_ok(128'(i));
      end
      chk(err_cnt == 32'd2, "side_err_cnt", 128'(err_cnt), 128'd2);
      chk(err_flags == 3'b110, "side_flags", 128'(err_flags), 128'd6);

      // random stream seeded near the 128-bit wrap
      do_clr();
      d = '1;
      d = d - 128'd3;
      send_ok(d);
      for (int i = 0; i < 300; i++) begin
         r = int'($urandom_range(0, 24));
         nd = d + 128'd1; k = 16'hFFFF; l = 1'b0; id = '0; de = '0;
         case (r)
            0: nd = d + 128'd2;
            1: nd = d;
            2: nd = {$urandom, $urandom, $urandom, $urandom};
            3: k  = 16'($urandom);
            4: id = 5'($urandom_range(1, 31));
            5: de = 5'($urandom_range(1, 31));
            6: l  = 1'b1;
            default: ;
         endcase
         send(nd, k, l, id, de, 1'b0);
         d = nd;
         if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      end

      // clr coincident with an accepted beat, then re-seed
      send(d + 128'd1, 16'hFFFF, 1'b0, 5'd0, 5'd0, 1'b1);
      chk({beat_cnt, err_cnt, err_flags, locked} == '0, "clr_counters",
          128'({beat_cnt, err_cnt, err_flags, locked}), 128'd0);
      d = {$urandom, $urandom, $urandom, $urandom};
      send_ok(d);
      send_ok(d + 128'd1);
      chk(err_cnt == 32'd0, "reseed_err_cnt", 128'(err_cnt), 128'd0);
      chk(beat_cnt == 64'd2, "reseed_beat_cnt", 128'(beat_cnt), 128'd2);

      // reset mid-run overrides en/clr and a pending beat
      tvalid = 1'b1; tdata = d + 128'd2; clr = 1'b1; rstn = 1'b0;
      @(posedge clk);
      #1;
      chk({tready, locked, err_pulse, err_flags, err_cnt, beat_cnt, rate, rate_vld} == '0,
          "midrun_reset", 128'({tready, err_flags, err_cnt, beat_cnt, rate}), 128'd0);
      chk(tready_b == 1'b0, "midrun_reset_b", 128'(tready_b), 128'd0);
      tvalid = 1'b0; clr = 1'b0;
      chk(sb.size() == 0, "sb_drained", 128'(sb.size()), 128'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
